jtframe_lfbuf_mem: RTL and testbench
====================================

JTFRAME_LFBUF_MEM -- requirements
Module: jtframe_lfbuf_mem

Interface
REQ-001 SHALL have parameter VW, default 8, line-count width.
REQ-002 SHALL have parameter HW, default 9, pixel-address width.
REQ-003 SHALL have parameter HLEN, default 256, words per line transferred (1..2^HW).
REQ-004 SHALL have ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- lhbl  in  1  horizontal blank, active low.
- vrender  in  VW  line currently rendered.
- frame  in  1  bank being written; reads use ~frame.
- ln_hs  in  1  one-cycle pulse, core starts drawing line ln_v.
- ln_v  in  VW  line number drawn by core.
- line  out  1  line-buffer half selector.
- fb_addr  out  HW  line-buffer read address for the dump.
- fb_din  in  16  line-buffer data, 1-cycle read latency.
- fb_clr  out  1  clears the line-buffer word at fb_addr.
- fb_done  out  1  one-cycle pulse, dump finished.
- rd_addr  out  HW  screen-buffer write address.
- fb_dout  out  16  screen-buffer write data.
- scr_we  out  1  screen-buffer write enable.
- mem_addr  out  VW+HW+1  {bank, row, column}.
- mem_din  out  16  write data to memory.
- mem_dout  in  16  read data from memory, valid when mem_ack is high.
- mem_req  out  1  request, held until acked.
- mem_we  out  1  1 = write, 0 = read; stable while mem_req is high.
- mem_ack  in  1  one-cycle completion pulse.

Function
REQ-005 SHALL use states IDLE, WFETCH, WREQ, WCLR, RREQ, DONE.
REQ-006 On ln_hs SHALL, in the same cycle:
- toggle line;
- latch the previously latched ln_v as the dump row;
- latch the new ln_v;
- clear the write counter;
- set wr_pend.
REQ-007 SHALL clear the row-valid flag on a frame change. The first ln_hs after a frame change SHALL skip the dump and pulse fb_done 2 cycles after ln_hs.
REQ-008 On the lhbl falling edge SHALL latch read row = vrender+1 (wraps modulo 2^VW), clear the read counter and set rd_pend.
REQ-009 In IDLE, rd_pend SHALL take priority over wr_pend. It SHALL also take priority at every write-word boundary (from WCLR), so a dump is preempted per word and later resumes at its saved counter.
REQ-010 Write word sequence:
- WFETCH: drive fb_addr = counter for one cycle.
- WREQ: mem_req=1, mem_we=1, mem_din=fb_din (registered), mem_addr={frame, dump row, counter}; hold until mem_ack.
- WCLR: fb_clr=1 for exactly one cycle at the same fb_addr.
REQ-011 After the WCLR of word HLEN-1, SHALL go to DONE, pulse fb_done one cycle, clear wr_pend, then return to IDLE.
REQ-012 Read word: RREQ with mem_req=1, mem_we=0, mem_addr={~frame, read row, counter}. On mem_ack SHALL, in the next cycle:
- pulse scr_we;
- drive rd_addr = counter and fb_dout = mem_dout.
REQ-013 After word HLEN-1 is acked, SHALL clear rd_pend.
REQ-014 An ln_hs arriving during an unfinished dump SHALL abort it: counter restarts and the new row is used. fb_done SHALL NOT pulse for the aborted line.
REQ-015 A new lhbl falling edge during an unfinished read SHALL restart the read with the new row.
REQ-016 mem_req SHALL deassert the cycle after mem_ack. A mem_ack seen with mem_req low SHALL be ignored.
REQ-017 fb_clr, fb_done and scr_we SHALL each be at most one cycle wide and never asserted simultaneously with each other.

Reset
REQ-018 While rst is high, SHALL:
- set state IDLE;
- drive line, fb_clr, fb_done, scr_we, mem_req, mem_we low;
- zero all addresses, counters and data outputs;
- clear rd_pend, wr_pend and row-valid.
REQ-019 Reset asserted mid-transfer SHALL abandon the transfer with no further fb_done, scr_we or mem_req.

Verification
REQ-020 Frame change, then ln_hs with ln_v=10 -> line toggles and fb_done pulses 2 cycles later with no mem_req.
REQ-021 ln_hs with ln_v=11, then fixed 3-cycle ack latency, HLEN=256, frame=0 -> 256 writes at mem_addr {0,10,0..255}, 256 fb_clr pulses, then one fb_done.
REQ-022 lhbl falls with vrender=255 and frame=1 -> reads at {0,0,0..255}, 256 scr_we pulses with rd_addr 0..255 and fb_dout equal to returned data.
REQ-023 lhbl falls during a dump at word 100 -> the write of word 100 completes, the full read line runs, then writes resume at word 101 with no duplicate or missing address.
REQ-024 rst pulsed during RREQ -> mem_req low next cycle, all outputs zero, no scr_we until the next lhbl edge.

Source files
------------

// File: rtl/jtframe_lfbuf_mem_if.sv
// Memory-side bus of the line-frame buffer: request/ack handshake with
// {bank, row, column} addressing and 16-bit data in both directions.
interface jtframe_lfbuf_mem_if #(
   parameter int VW = 8,
   parameter int HW = 9
);
   logic [VW+HW:0] mem_addr;
   logic [15:0]    mem_din;
   logic [15:0]    mem_dout;
   logic           mem_req;
   logic           mem_we;
   logic           mem_ack;

   modport master (
      output mem_addr, mem_din, mem_req, mem_we,
      input  mem_dout, mem_ack
   );

   modport slave (
      input  mem_addr, mem_din, mem_req, mem_we,
      output mem_dout, mem_ack
   );
endinterface

// File: rtl/jtframe_lfbuf_mem.sv
// Moves finished lines from the line buffer into frame memory and fetches
// the next display line from the opposite bank into the screen buffer.
module jtframe_lfbuf_mem #(
   parameter int VW   = 8,
   parameter int HW   = 9,
   parameter int HLEN = 256
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          lhbl,
   input  logic [VW-1:0] vrender,
   input  logic          frame,
   input  logic          ln_hs,
   input  logic [VW-1:0] ln_v,
   output logic          line,
   output logic [HW-1:0] fb_addr,
   input  logic [15:0]   fb_din,
   output logic          fb_clr,
   output logic          fb_done,
   output logic [HW-1:0] rd_addr,
   output logic [15:0]   fb_dout,
   output logic          scr_we,
   jtframe_lfbuf_mem_if.master mem
);
   localparam logic [HW-1:0] LAST = HW'(HLEN - 1);

   typedef enum logic [2:0] {IDLE, WFETCH, WREQ, WCLR, RREQ, DONE} state_t;

   state_t         st_q, st_d;
   logic           line_q, line_d;
   logic [VW-1:0]  lnv_q, lnv_d, dump_row_q, dump_row_d, rd_row_q, rd_row_d;
   logic [HW-1:0]  wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
   logic [HW-1:0]  fb_addr_q, fb_addr_d, rd_addr_q, rd_addr_d;
   logic           wr_pend_q, wr_pend_d, skip_q, skip_d, wr_abort_q, wr_abort_d;
   logic           rd_pend_q, rd_pend_d, rd_abort_q, rd_abort_d;
   logic           row_valid_q, row_valid_d, fetch_q, fetch_d, scr_we_q, scr_we_d;
   logic [VW+HW:0] mem_addr_q, mem_addr_d;
   logic [15:0]    mem_din_q, mem_din_d, fb_dout_q, fb_dout_d;
   logic           frame_q, lhbl_q, frame_chg, lhbl_fall, req, we;

   assign frame_chg = frame != frame_q;
   assign lhbl_fall = lhbl_q & ~lhbl;

   always_comb begin
      st_d        = st_q;
      line_d      = line_q;
      lnv_d       = lnv_q;
      dump_row_d  = dump_row_q;
      rd_row_d    = rd_row_q;
      wr_cnt_d    = wr_cnt_q;
      rd_cnt_d    = rd_cnt_q;
      fb_addr_d   = fb_addr_q;
      rd_addr_d   = rd_addr_q;
      wr_pend_d   = wr_pend_q;
      skip_d      = skip_q;
      wr_abort_d  = wr_abort_q;
      rd_pend_d   = rd_pend_q;
      rd_abort_d  = rd_abort_q;
      row_valid_d = row_valid_q;
      mem_addr_d  = mem_addr_q;
      mem_din_d   = mem_din_q;
      fb_dout_d   = fb_dout_q;
      fetch_d     = (st_q == WFETCH);
      scr_we_d    = 1'b0;
      req         = 1'b0;
      we          = 1'b0;
      fb_clr      = 1'b0;
      fb_done     = 1'b0;

      // fb_din answers the address presented during WFETCH one cycle later
      if (fetch_q) mem_din_d = fb_din;

      case (st_q)
         IDLE: begin
            if (rd_pend_q) begin
               st_d       = RREQ;
               mem_addr_d = {~frame, rd_row_q, rd_cnt_q};
               rd_abort_d = 1'b0;
            end else if (wr_pend_q) begin
               if (skip_q) begin
                  st_d      = DONE;
                  wr_pend_d = 1'b0;
                  skip_d    = 1'b0;
               end else begin
                  st_d       = WFETCH;
                  fb_addr_d  = wr_cnt_q;
                  wr_abort_d = 1'b0;
               end
            end
         end
         WFETCH: begin
            st_d       = WREQ;
            mem_addr_d = {frame, dump_row_q, fb_addr_q};
         end
         WREQ: begin
            req = 1'b1;
            we  = 1'b1;
            if (mem.mem_ack) st_d = WCLR;
         end
         WCLR: begin
            fb_clr = 1'b1;
            if (!wr_abort_q && fb_addr_q == LAST) begin
               st_d      = DONE;
               wr_pend_d = 1'b0;
               skip_d    = 1'b0;
            end else begin
               if (!wr_abort_q) wr_cnt_d = fb_addr_q + 1'b1;
               if (rd_pend_q) begin
                  st_d       = RREQ;
                  mem_addr_d = {~frame, rd_row_q, rd_cnt_q};
                  rd_abort_d = 1'b0;
               end else begin
                  st_d = IDLE;
               end
            end
         end
         RREQ: begin
            req = 1'b1;
            if (mem.mem_ack) begin
               st_d = IDLE;
               // a word requested for a row that was since replaced is dropped
               if (!rd_abort_q) begin
                  scr_we_d  = 1'b1;
                  rd_addr_d = rd_cnt_q;
                  fb_dout_d = mem.mem_dout;
                  if (rd_cnt_q == LAST) rd_pend_d = 1'b0;
                  else                  rd_cnt_d  = rd_cnt_q + 1'b1;
               end
            end
         end
         DONE: begin
            fb_done = 1'b1;
            st_d    = IDLE;
         end
         default: st_d = IDLE;
      endcase

      if (frame_chg) row_valid_d = 1'b0;

      if (ln_hs) begin
         line_d      = ~line_q;
         dump_row_d  = lnv_q;
         lnv_d       = ln_v;
         wr_cnt_d    = '0;
         wr_pend_d   = 1'b1;
         skip_d      = !(row_valid_q && !frame_chg);
         row_valid_d = 1'b1;
         if (st_d == WFETCH || st_d == WREQ || st_d == WCLR) wr_abort_d = 1'b1;
      end

      if (lhbl_fall) begin
         rd_row_d  = vrender + 1'b1;
         rd_cnt_d  = '0;
         rd_pend_d = 1'b1;
         if (st_d == RREQ) rd_abort_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      frame_q <= frame;
      lhbl_q  <= lhbl;
      if (rst) begin
         st_q        <= IDLE;
         line_q      <= 1'b0;
         lnv_q       <= '0;
         dump_row_q  <= '0;
         rd_row_q    <= '0;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         fb_addr_q   <= '0;
         rd_addr_q   <= '0;
         wr_pend_q   <= 1'b0;
         skip_q      <= 1'b0;
         wr_abort_q  <= 1'b0;
         rd_pend_q   <= 1'b0;
         rd_abort_q  <= 1'b0;
         row_valid_q <= 1'b0;
         fetch_q     <= 1'b0;
         scr_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_din_q   <= '0;
         fb_dout_q   <= '0;
      end else begin
         st_q        <= st_d;
         line_q      <= line_d;
         lnv_q       <= lnv_d;
         dump_row_q  <= dump_row_d;
         rd_row_q    <= rd_row_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         fb_addr_q   <= fb_addr_d;
         rd_addr_q   <= rd_addr_d;
         wr_pend_q   <= wr_pend_d;
         skip_q      <= skip_d;
         wr_abort_q  <= wr_abort_d;
         rd_pend_q   <= rd_pend_d;
         rd_abort_q  <= rd_abort_d;
         row_valid_q <= row_valid_d;
         fetch_q     <= fetch_d;
         scr_we_q    <= scr_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_din_q   <= mem_din_d;
         fb_dout_q   <= fb_dout_d;
      end
   end

   assign line         = line_q;
   assign fb_addr      = fb_addr_q;
   assign rd_addr      = rd_addr_q;
   assign fb_dout      = fb_dout_q;
   assign scr_we       = scr_we_q;
   assign mem.mem_addr = mem_addr_q;
   assign mem.mem_din  = mem_din_q;
   assign mem.mem_req  = req;
   assign mem.mem_we   = we;
endmodule

// File: tb/tb_jtframe_lfbuf_mem.sv
// Scoreboard bench: stimulus pushes expected memory transactions, line-buffer
// clears, screen writes and done pulses; a monitor pops them as the DUT emits them.
module tb_jtframe_lfbuf_mem;
   localparam int VW = 8;
   localparam int HW = 9;

   typedef struct packed {
      logic        we;
      logic [17:0] addr;
      logic [15:0] data;
   } mem_t;

   typedef struct packed {
      logic [8:0]  addr;
      logic [15:0] data;
   } scr_t;

   logic        clk = 1'b0;
   logic        rst, lhbl, frame, ln_hs;
   logic [7:0]  vrender, ln_v;
   logic        line, fb_clr, fb_done, scr_we;
   logic [8:0]  fb_addr, rd_addr;
   logic [15:0] fb_din, fb_dout;
   logic        refill;
   logic [15:0] lb [512];
   int unsigned ack_cnt;

   mem_t        exp_mem [$];
   logic [8:0]  exp_clr [$];
   scr_t        exp_scr [$];
   int          exp_done [$];
   int          n_chk = 0;
   int          n_fail = 0;

   jtframe_lfbuf_mem_if #(.VW(VW), .HW(HW)) mem_if ();

   jtframe_lfbuf_mem #(.VW(VW), .HW(HW), .HLEN(256)) dut (
      .clk(clk), .rst(rst), .lhbl(lhbl), .vrender(vrender), .frame(frame),
      .ln_hs(ln_hs), .ln_v(ln_v), .line(line), .fb_addr(fb_addr),
      .fb_din(fb_din), .fb_clr(fb_clr), .fb_done(fb_done), .rd_addr(rd_addr),
      .fb_dout(fb_dout), .scr_we(scr_we), .mem(mem_if)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] pat(int i);
      return 16'hC000 | 16'(i);
   endfunction

   function automatic logic [15:0] rdata(logic [17:0] a);
      return a[15:0] ^ 16'h3C3C;
   endfunction

   // line buffer: one-cycle read latency, clear-on-fb_clr
   always @(posedge clk) begin
      fb_din <= lb[fb_addr];
      if (refill) begin
         for (int i = 0; i < 512; i++) lb[i] <= pat(i);
      end else if (fb_clr) begin
         lb[fb_addr] <= 16'h0;
      end
   end

   // memory: acks every request after a fixed latency
   always @(posedge clk) begin
      mem_if.mem_ack <= 1'b0;
      if (ack_cnt != 0) begin
         ack_cnt <= ack_cnt - 1;
         if (ack_cnt == 1) begin
            mem_if.mem_ack  <= 1'b1;
            mem_if.mem_dout <= rdata(mem_if.mem_addr);
         end
      end else if (mem_if.mem_req && !mem_if.mem_ack) begin
         ack_cnt <= 3;
      end
   end

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic monitor();
      mem_t e;
      scr_t s;
      logic [8:0] c;
      forever begin
         @(negedge clk);
         if (mem_if.mem_req && mem_if.mem_ack) begin
            check("mem_txn_expected", exp_mem.size() != 0, 1);
            if (exp_mem.size() != 0) begin
               e = exp_mem.pop_front();
               check("mem_we", mem_if.mem_we, e.we);
               check("mem_addr", mem_if.mem_addr, e.addr);
               if (e.we) check("mem_din", mem_if.mem_din, e.data);
            end
         end
         if (fb_clr) begin
            check("fb_clr_expected", exp_clr.size() != 0, 1);
            if (exp_clr.size() != 0) begin
               c = exp_clr.pop_front();
               check("fb_clr_addr", fb_addr, c);
            end
         end
         if (scr_we) begin
            check("scr_we_expected", exp_scr.size() != 0, 1);
            if (exp_scr.size() != 0) begin
               s = exp_scr.pop_front();
               check("rd_addr", rd_addr, s.addr);
               check("fb_dout", fb_dout, s.data);
            end
         end
         if (fb_done) begin
            check("fb_done_expected", exp_done.size() != 0, 1);
            if (exp_done.size() != 0) void'(exp_done.pop_front());
         end
         if (fb_clr || fb_done || scr_we)
            check("strobe_exclusive", int'(fb_clr) + int'(fb_done) + int'(scr_we), 1);
      end
   endtask

   function automatic int pending();
      return exp_mem.size() + exp_clr.size() + exp_scr.size() + exp_done.size();
   endfunction

   task automatic wait_empty(string name, int budget);
      for (int c = 0; c < budget && pending() != 0; c++) @(negedge clk);
      repeat (4) @(negedge clk);
      check(name, pending(), 0);
   endtask

   task automatic pulse_hs(logic [7:0] v);
      @(negedge clk);
      ln_v  = v;
      ln_hs = 1'b1;
      @(negedge clk);
      ln_hs = 1'b0;
   endtask

   task automatic push_reads(logic [7:0] row);
      for (int i = 0; i < 256; i++) begin
         exp_mem.push_back({1'b0, 1'b0, row, 9'(i), 16'h0});
         exp_scr.push_back({9'(i), rdata({1'b0, row, 9'(i)})});
      end
   endtask

   task automatic push_writes(logic bank, logic [7:0] row, int first, int last);
      for (int i = first; i <= last; i++) begin
         exp_mem.push_back({1'b1, bank, row, 9'(i), pat(i)});
         exp_clr.push_back(9'(i));
      end
   endtask

   initial begin
      logic found;
      logic any_req;
      rst = 1'b1; lhbl = 1'b1; frame = 1'b1; ln_hs = 1'b0; ln_v = '0;
      vrender = '0; refill = 1'b1; ack_cnt = 0;
      mem_if.mem_ack = 1'b0; mem_if.mem_dout = '0;
      fork
         monitor();
      join_none

      // reset state
      repeat (3) @(negedge clk);
      refill = 1'b0;
      check("rst_line", line, 0);
      check("rst_strobes", {fb_clr, fb_done, scr_we}, 0);
      check("rst_mem_ctl", {mem_if.mem_req, mem_if.mem_we}, 0);
      check("rst_addrs", {fb_addr, rd_addr, mem_if.mem_addr}, 0);
      check("rst_data", {fb_dout, mem_if.mem_din}, 0);
      rst = 1'b0;

      // frame change, first ln_hs skips the dump
      @(negedge clk);
      frame = 1'b0;
      repeat (2) @(negedge clk);
      exp_done.push_back(1);
      pulse_hs(8'd10);
      check("skip_line_toggle", line, 1);
      check("skip_done_early", fb_done, 0);
      @(negedge clk);
      check("skip_done_at_2", fb_done, 1);
      check("skip_no_req", mem_if.mem_req, 0);
      @(negedge clk);
      check("skip_done_1cycle", fb_done, 0);
      wait_empty("skip_drain", 50);

      // full dump of row 10 into bank 0
      push_writes(1'b0, 8'd10, 0, 255);
      exp_done.push_back(2);
      pulse_hs(8'd11);
      check("dump_line_toggle", line, 0);
      wait_empty("dump_drain", 5000);
      check("lb_cleared_first", lb[0], 0);
      check("lb_cleared_last", lb[255], 0);
      check("lb_untouched_256", lb[256], pat(256));

      // read of vrender+1 wrapping to row 0 from bank ~frame
      @(negedge clk);
      frame = 1'b1;
      vrender = 8'd255;
      push_reads(8'd0);
      @(negedge clk);
      lhbl = 1'b0;
      repeat (3) @(negedge clk);
      lhbl = 1'b1;
      wait_empty("read_drain", 5000);

      // dump preempted by a read at word 100
      refill = 1'b1;
      @(negedge clk);
      refill = 1'b0;
      exp_done.push_back(3);
      pulse_hs(8'd20);
      wait_empty("skip2_drain", 50);
      push_writes(1'b1, 8'd20, 0, 100);
      pulse_hs(8'd21);
      found = 1'b0;
      for (int c = 0; c < 3000 && !found; c++) begin
         @(negedge clk);
         if (mem_if.mem_req && mem_if.mem_we && mem_if.mem_addr[8:0] == 9'd100) found = 1'b1;
      end
      check("reach_word100", found, 1);
      push_reads(8'd51);
      push_writes(1'b1, 8'd20, 101, 255);
      exp_done.push_back(4);
      vrender = 8'd50;
      lhbl = 1'b0;
      repeat (3) @(negedge clk);
      lhbl = 1'b1;
      wait_empty("preempt_drain", 8000);

      // reset during a read request
      @(negedge clk);
      vrender = 8'd5;
      lhbl = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk);
         if (mem_if.mem_req && !mem_if.mem_we) found = 1'b1;
      end
      check("rst_test_req_seen", found, 1);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_req_low", mem_if.mem_req, 0);
      check("midrst_outputs", {line, fb_addr, rd_addr, fb_dout, mem_if.mem_addr, mem_if.mem_din}, 0);
      rst = 1'b0;
      lhbl = 1'b1;
      any_req = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (mem_if.mem_req || scr_we || fb_done) any_req = 1'b1;
      end
      check("midrst_quiet", any_req, 0);
      check("final_queues", pending(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
